// File: rtl/fsm2_pkg.sv
// Shared definitions for the fsm2 pattern generator and its receive-side checker:
// phase constants, the 8-entry symbol table and the checker FSM state encoding.
package fsm2_pkg;

    localparam logic [2:0] S0 = 3'd0;
    localparam logic [2:0] S1 = 3'd1;
    localparam logic [2:0] S2 = 3'd2;
    localparam logic [2:0] S3 = 3'd3;
    localparam logic [2:0] S4 = 3'd4;
    localparam logic [2:0] S5 = 3'd5;
    localparam logic [2:0] S6 = 3'd6;
    localparam logic [2:0] S7 = 3'd7;

    // Entry i holds the symbol emitted at phase i (index 0 is the low nibble).
    localparam logic [7:0][3:0] PAT_TABLE = {
        4'b0111, 4'b0011, 4'b0000, 4'b0000,
        4'b1000, 4'b0010, 4'b0001, 4'b0000
    };

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        VERIFY = 2'd1,
        LOCK   = 2'd2
    } fsm2_state_e;

    function automatic logic [3:0] pat_sym(input logic [2:0] ph);
        return PAT_TABLE[ph];
    endfunction

endpackage

// File: rtl/fsm2_pat_lut.sv
// Combinational pattern lookup: symbol-to-phase for the unambiguous symbols,
// and phase-to-expected-symbol for tracking.
module fsm2_pat_lut
    import fsm2_pkg::*;
(
    input  logic [3:0] sym,
    input  logic [2:0] phase,
    output logic       uniq,
    output logic [2:0] uniq_phase,
    output logic [3:0] exp_sym
);

    // 0000 occurs at three phases, so it can never establish alignment.
    always_comb begin
        uniq       = 1'b0;
        uniq_phase = S0;
        case (sym)
            4'b0001: begin uniq = 1'b1; uniq_phase = S1; end
            4'b0010: begin uniq = 1'b1; uniq_phase = S2; end
            4'b1000: begin uniq = 1'b1; uniq_phase = S3; end
            4'b0011: begin uniq = 1'b1; uniq_phase = S6; end
            4'b0111: begin uniq = 1'b1; uniq_phase = S7; end
            default: begin uniq = 1'b0; uniq_phase = S0; end
        endcase
    end

    assign exp_sym = pat_sym(phase);

endmodule

// File: rtl/fsm2_checker.sv
// Receive-side checker for the fsm2 8-phase pattern: acquires phase, locks, flags errors.
// Optional saturating error counter and err_cnt port enabled by FSM2_CHECKER_ERR_CNT_EN.
module fsm2_checker
    import fsm2_pkg::*;
#(
    parameter int LOCK_CNT = 4,
    parameter int MISS_MAX = 3,
    parameter int CNT_W    = 16
) (
    input  logic       ck,
    input  logic       rs,
    input  logic [3:0] d,
    input  logic       d_vld,
    output logic       locked,
    output logic [2:0] phase,
    output logic       err,
    output logic       frame
`ifdef FSM2_CHECKER_ERR_CNT_EN
    ,
    output logic [CNT_W-1:0] err_cnt
`endif
);

    if (LOCK_CNT < 1 || LOCK_CNT > 8) begin : g_bad_lock_cnt
        $error("fsm2_checker: LOCK_CNT must be in 1..8");
    end
    if (MISS_MAX < 1 || MISS_MAX > 7) begin : g_bad_miss_max
        $error("fsm2_checker: MISS_MAX must be in 1..7");
    end
    if (CNT_W < 1) begin : g_bad_cnt_w
        $error("fsm2_checker: CNT_W must be at least 1");
    end

    fsm2_state_e state_q, state_d;
    logic [2:0]  phase_q, phase_d;
    logic [3:0]  good_cnt_q, good_cnt_d;
    logic [2:0]  miss_cnt_q, miss_cnt_d;
    logic        err_q, err_d;
    logic        frame_q, frame_d;

    logic        uniq;
    logic [2:0]  uniq_phase;
    logic [3:0]  exp_sym;
    logic        sym_ok;

    fsm2_pat_lut u_lut (
        .sym        (d),
        .phase      (phase_q),
        .uniq       (uniq),
        .uniq_phase (uniq_phase),
        .exp_sym    (exp_sym)
    );

    assign sym_ok = (d == exp_sym);

    always_comb begin
        state_d    = state_q;
        phase_d    = phase_q;
        good_cnt_d = good_cnt_q;
        miss_cnt_d = miss_cnt_q;
        err_d      = 1'b0;
        frame_d    = 1'b0;
        if (d_vld) begin
            case (state_q)
                HUNT: begin
                    if (uniq) begin
                        phase_d    = uniq_phase + 3'd1;
                        good_cnt_d = 4'd1;
                        state_d    = (LOCK_CNT == 1) ? LOCK : VERIFY;
                    end
                end
                VERIFY: begin
                    // A mismatch here is dropped rather than re-used for acquisition.
                    if (sym_ok) begin
                        phase_d    = phase_q + 3'd1;
                        good_cnt_d = good_cnt_q + 4'd1;
                        if (good_cnt_q + 4'd1 >= 4'(LOCK_CNT)) begin
                            state_d = LOCK;
                        end
                    end else begin
                        good_cnt_d = 4'd0;
                        state_d    = HUNT;
                    end
                end
                LOCK: begin
                    phase_d = phase_q + 3'd1;
                    if (sym_ok) begin
                        miss_cnt_d = 3'd0;
                        frame_d    = (phase_q == S7);
                    end else begin
                        err_d = 1'b1;
                        if (miss_cnt_q + 3'd1 >= 3'(MISS_MAX)) begin
                            miss_cnt_d = 3'd0;
                            good_cnt_d = 4'd0;
                            state_d    = HUNT;
                        end else begin
                            miss_cnt_d = miss_cnt_q + 3'd1;
                        end
                    end
                end
                default: begin
                    state_d = HUNT;
                end
            endcase
        end
    end

    always_ff @(posedge ck) begin
        if (rs) begin
            state_q    <= HUNT;
            phase_q    <= S0;
            good_cnt_q <= 4'd0;
            miss_cnt_q <= 3'd0;
            err_q      <= 1'b0;
            frame_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            phase_q    <= phase_d;
            good_cnt_q <= good_cnt_d;
            miss_cnt_q <= miss_cnt_d;
            err_q      <= err_d;
            frame_q    <= frame_d;
        end
    end

`ifdef FSM2_CHECKER_ERR_CNT_EN
    logic [CNT_W-1:0] err_cnt_q, err_cnt_d;

    // Saturates instead of wrapping; only reset clears it, not loss of lock.
    always_comb begin
        err_cnt_d = err_cnt_q;
        if (err_d && (err_cnt_q != '1)) begin
            err_cnt_d = err_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge ck) begin
        if (rs) begin
            err_cnt_q <= '0;
        end else begin
            err_cnt_q <= err_cnt_d;
        end
    end

    assign err_cnt = err_cnt_q;
`endif

    assign locked = (state_q == LOCK);
    assign phase  = phase_q;
    assign err    = err_q;
    assign frame  = frame_q;

endmodule

// File: tb/tb_fsm2_checker.sv
// Directed self-checking bench for fsm2_checker with default parameters;
// err_cnt is checked only when FSM2_CHECKER_ERR_CNT_EN is defined.
module tb_fsm2_checker;

    logic       ck = 1'b0;
    logic       rs = 1'b1;
    logic [3:0] d = 4'h0;
    logic       d_vld = 1'b0;
    logic       locked;
    logic [2:0] phase;
    logic       err;
    logic       frame;
`ifdef FSM2_CHECKER_ERR_CNT_EN
    logic [15:0] err_cnt;
`endif

    int total_checks = 0;
    int bad_checks = 0;
    logic [3:0] pat [8];

    always #5 ck = ~ck;

    fsm2_checker #(
        .LOCK_CNT (4),
        .MISS_MAX (3),
        .CNT_W    (16)
    ) dut (
        .ck      (ck),
        .rs      (rs),
        .d       (d),
        .d_vld   (d_vld),
        .locked  (locked),
        .phase   (phase),
        .err     (err),
        .frame   (frame)
`ifdef FSM2_CHECKER_ERR_CNT_EN
        ,
        .err_cnt (err_cnt)
`endif
    );

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total_checks++;
        if (got !== exp) begin
            bad_checks++;
            $display("[TB] FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Drive away from the active edge, then sample 1 time unit after it.
    task automatic applyStimulus(input logic [3:0] sym, input logic vld, input logic rst);
        @(negedge ck);
        d = sym;
        d_vld = vld;
        rs = rst;
        @(posedge ck);
        #1;
    endtask

    task automatic checkErrCnt(input string tag, input int exp);
`ifdef FSM2_CHECKER_ERR_CNT_EN
        checkOutput(tag, 32'(err_cnt), 32'(exp));
`else
        if (exp < 0) $display("[TB] unexpected negative count for %s", tag);
`endif
    endtask

    initial begin
        logic [3:0] seq4 [6];
        logic [3:0] seq5 [7];
        logic       corrupt;
        logic [3:0] sym;

        pat[0] = 4'b0000; pat[1] = 4'b0001; pat[2] = 4'b0010; pat[3] = 4'b1000;
        pat[4] = 4'b0000; pat[5] = 4'b0000; pat[6] = 4'b0011; pat[7] = 4'b0111;

        applyStimulus(4'h0, 1'b0, 1'b1);
        applyStimulus(4'h0, 1'b0, 1'b1);
        checkOutput("rst_locked", 32'(locked), 32'd0);
        checkOutput("rst_phase", 32'(phase), 32'd0);
        checkOutput("rst_err", 32'(err), 32'd0);
        checkOutput("rst_frame", 32'(frame), 32'd0);
        checkErrCnt("rst_err_cnt", 0);

        // Clean stream from phase 0: lock after edge 4, frame on edges 7, 15, 23...
        for (int k = 0; k < 40; k++) begin
            applyStimulus(pat[k % 8], 1'b1, 1'b0);
            checkOutput($sformatf("clean_locked_%0d", k), 32'(locked), 32'(k >= 4));
            checkOutput($sformatf("clean_frame_%0d", k), 32'(frame), 32'((k % 8) == 7));
            checkOutput($sformatf("clean_err_%0d", k), 32'(err), 32'd0);
            if (k == 1) checkOutput("acq_phase", 32'(phase), 32'd2);
        end
        checkOutput("clean_phase_wrap", 32'(phase), 32'd0);
        checkErrCnt("clean_err_cnt", 0);

        // Single corruption at 41, triple at 48..50 (drops lock), re-lock via 1000 at 51.
        for (int g = 40; g < 56; g++) begin
            corrupt = (g == 41) || (g >= 48 && g <= 50);
            sym = corrupt ? 4'hF : pat[g % 8];
            applyStimulus(sym, 1'b1, 1'b0);
            checkOutput($sformatf("cor_err_%0d", g), 32'(err), 32'(corrupt));
            checkOutput($sformatf("cor_locked_%0d", g), 32'(locked), 32'(!(g >= 50 && g <= 53)));
            checkOutput($sformatf("cor_frame_%0d", g), 32'(frame), 32'(g == 47 || g == 55));
            if (g == 41) checkErrCnt("cor_err_cnt_1", 1);
            if (g == 50) checkErrCnt("cor_err_cnt_4", 4);
            if (g == 51) checkOutput("reacq_phase", 32'(phase), 32'd4);
            if (g == 54) checkOutput("relock_phase", 32'(phase), 32'd7);
        end
        checkErrCnt("cor_err_cnt_hold", 4);

        // Reset, then start the stream at phase 4: acquire on 0011.
        applyStimulus(4'hF, 1'b1, 1'b1);
        checkOutput("rst2_locked", 32'(locked), 32'd0);
        checkErrCnt("rst2_err_cnt", 0);
        seq4[0] = 4'b0000; seq4[1] = 4'b0000; seq4[2] = 4'b0011;
        seq4[3] = 4'b0111; seq4[4] = 4'b0000; seq4[5] = 4'b0001;
        for (int i = 0; i < 6; i++) begin
            applyStimulus(seq4[i], 1'b1, 1'b0);
            checkOutput($sformatf("ph4_locked_%0d", i), 32'(locked), 32'(i == 5));
            checkOutput($sformatf("ph4_err_%0d", i), 32'(err), 32'd0);
            if (i == 1) checkOutput("ph4_hunt_phase", 32'(phase), 32'd0);
            if (i == 2) checkOutput("ph4_acq_phase", 32'(phase), 32'd7);
            if (i == 5) checkOutput("ph4_lock_phase", 32'(phase), 32'd2);
        end

        // VERIFY mismatch returns to HUNT; 0011 must then acquire afresh.
        applyStimulus(4'h0, 1'b1, 1'b1);
        seq5[0] = 4'b0001; seq5[1] = 4'b0010; seq5[2] = 4'b0100; seq5[3] = 4'b0011;
        seq5[4] = 4'b0111; seq5[5] = 4'b0000; seq5[6] = 4'b0001;
        for (int i = 0; i < 7; i++) begin
            applyStimulus(seq5[i], 1'b1, 1'b0);
            checkOutput($sformatf("ver_locked_%0d", i), 32'(locked), 32'(i == 6));
            checkOutput($sformatf("ver_err_%0d", i), 32'(err), 32'd0);
            if (i == 3) checkOutput("ver_reacq_phase", 32'(phase), 32'd7);
        end
        checkErrCnt("ver_err_cnt", 0);

        // d_vld low freezes everything even with garbage on d.
        for (int i = 0; i < 5; i++) begin
            applyStimulus(4'hF, 1'b0, 1'b0);
            checkOutput($sformatf("hold_locked_%0d", i), 32'(locked), 32'd1);
            checkOutput($sformatf("hold_phase_%0d", i), 32'(phase), 32'd2);
            checkOutput($sformatf("hold_err_%0d", i), 32'(err), 32'd0);
            checkOutput($sformatf("hold_frame_%0d", i), 32'(frame), 32'd0);
        end
        applyStimulus(4'b0010, 1'b1, 1'b0);
        checkOutput("resume_locked", 32'(locked), 32'd1);
        checkOutput("resume_phase", 32'(phase), 32'd3);
        checkOutput("resume_err", 32'(err), 32'd0);

        // Reset wins over a valid mismatching symbol while locked.
        applyStimulus(4'hF, 1'b1, 1'b1);
        checkOutput("rst3_locked", 32'(locked), 32'd0);
        checkOutput("rst3_phase", 32'(phase), 32'd0);
        checkOutput("rst3_err", 32'(err), 32'd0);
        checkOutput("rst3_frame", 32'(frame), 32'd0);
        checkErrCnt("rst3_err_cnt", 0);
        applyStimulus(4'b0000, 1'b1, 1'b0);
        checkOutput("post_rst_locked", 32'(locked), 32'd0);
        checkOutput("post_rst_phase", 32'(phase), 32'd0);

        $display("test done: total=%0d bad=%0d", total_checks, bad_checks);
        $finish;
    end

endmodule

// File: doc/fsm2_checker.md
# fsm2_checker

Receive-side checker for the 8-phase 4-bit pattern sequence produced by the `fsm2` sequence generator. The repeating pattern, phase 0..7, is 0000, 0001, 0010, 1000, 0000, 0000, 0011, 0111. The block samples the generator's 4-bit output and acquires phase alignment. It declares lock after a run of correct symbols and flags symbol errors while locked. It sits downstream of the generator, or at the far end of any link carrying it, as a self-test and monitor block.

## Interface
- `LOCK_CNT`, default 4: consecutive correct symbols, including the acquiring symbol, needed to enter LOCK. Legal range 1..8.
- `MISS_MAX`, default 3: consecutive mismatches in LOCK that drop back to HUNT. Legal range 1..7.
- `CNT_W`, default 16: width of the error counter.
- `ck`, input, 1: clock. Single clock domain.
- `rs`, input, 1: reset, synchronous, active-high.
- `d`, input, 4: sampled pattern symbol.
- `d_vld`, input, 1: `d` is valid this cycle. Tie high when the checker is attached directly to the generator.
- `locked`, output, 1: high while the FSM is in LOCK.
- `phase`, output, 3: phase expected for the next valid symbol. Meaningful in VERIFY and LOCK.
- `err`, output, 1: one-cycle pulse for each mismatch detected in LOCK.
- `frame`, output, 1: one-cycle pulse when a correct phase-7 symbol is accepted in LOCK.
- `err_cnt`, output, CNT_W: saturating count of LOCK mismatches. Present only with ERR_CNT_EN.

## Operation
- FSM states: HUNT, VERIFY, LOCK. Internal counters: `good_cnt` (0..8) and `miss_cnt` (0..7).
- The phase-to-symbol lookup is fixed as the table in the summary.
- Unique symbols and their phases: 0001→1, 0010→2, 1000→3, 0011→6, 0111→7. Symbol 0000 is ambiguous (phases 0, 4, 5) and never acquires.
- HUNT:
  - A valid unique symbol at phase p sets `phase` = p+1 (mod 8) and `good_cnt` = 1.
  - If LOCK_CNT = 1, go to LOCK. Otherwise go to VERIFY.
  - Symbols that are not unique, and any symbol that does not map to a phase (e.g. 0100, 1111), are ignored.
- VERIFY:
  - Valid `d` equal to the expected symbol: `phase`++ and `good_cnt`++. Enter LOCK when `good_cnt` reaches LOCK_CNT.
  - Valid mismatch: go to HUNT. The mismatching symbol is discarded and is not used for re-acquisition. No `err` pulse is produced.
- LOCK:
  - Every valid symbol advances `phase` (mod 8, wrapping 7→0).
  - Match: clear `miss_cnt`. If the accepted phase is 7, pulse `frame`.
  - Mismatch: pulse `err`, increment `err_cnt` (saturating at all-ones), increment `miss_cnt`.
  - When `miss_cnt` reaches MISS_MAX: go to HUNT and clear `miss_cnt`. The `err` pulse for that symbol is still issued.
- `d_vld` low: state, counters and `phase` hold. `err` and `frame` are low.
- Reset values:
  - State HUNT, `phase` = 0, `good_cnt` = 0, `miss_cnt` = 0.
  - Outputs: `locked` = 0, `err` = 0, `frame` = 0, `err_cnt` = 0.

## Timing
- All outputs are registered. The response to the symbol sampled at edge k is visible after edge k.
- `rs` dominates everything, including `d_vld` and in-progress VERIFY or LOCK. Reset mid-operation returns the block to HUNT with all counters cleared in one cycle.
- Acquisition latency with generator and checker reset together and `d_vld` = 1, defaults:
  - Edge 0 samples 0000 (ignored).
  - Edge 1 samples 0001 (acquire, `good_cnt` = 1).
  - Edges 2, 3, 4 match.
  - `locked` is high after edge 4.
  - The first `frame` pulse follows edge 7.
- `err` and `frame` are never high in the same cycle.
- `err_cnt` saturates and does not wrap. It is not cleared on loss of lock, only by `rs`.

## Configuration
- `FSM2_CHECKER_ERR_CNT_EN` defined: the `err_cnt` port and its counter are present and behave as specified above.
- Not defined: the `err_cnt` port and its counter logic are removed. `err` and `locked` behaviour is unchanged.

## Structure
- Shared package `fsm2_pkg`:
  - 3-bit phase constants S0..S7.
  - The 8-entry pattern symbol table.
  - The FSM state encoding HUNT/VERIFY/LOCK.
  - The generator should use the same package.
- One sub-module, `fsm2_pat_lut`, purely combinational:
  - Input: symbol. Outputs: `uniq` and `uniq_phase`.
  - Input: phase. Output: `exp_sym`.

## Test plan
- Reset both blocks, run `fsm2` into `d` with `d_vld` = 1 for 40 cycles → `locked` rises after edge 4, `frame` pulses every 8 cycles starting after edge 7, no `err`, `err_cnt` = 0.
- Start the stream at phase 4 (0000, 0000, 0011, …) → acquire on 0011, `phase` = 7, `locked` rises after the 4th consecutive good symbol.
- While locked, corrupt one symbol to 1111 → a single `err` pulse, `err_cnt` = 1, `locked` stays high, `frame` cadence is unchanged.
- While locked, corrupt 3 consecutive symbols → three `err` pulses, `locked` falls after the 3rd, `err_cnt` = 3, re-lock on the next unique symbol plus 3 good ones.
- Mismatch during VERIFY (0001, 0010, 0100) → back to HUNT, no `err`, `locked` stays 0.
- Toggle `d_vld` low for 5 cycles mid-LOCK, then assert `rs` one cycle → state frozen while `d_vld` is low; after `rs`, `locked` = 0, `phase` = 0, `err_cnt` = 0.
